// File: rtl/nios2_debug_ocimem_pkg.sv
// Shared definitions for the Nios II debug on-chip memory controller:
// arbiter state encoding and the field positions inside the 38-bit jdo
// command word delivered by the debug slave's system-clock stage.
package nios2_debug_ocimem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CPU_RD  = 2'd1,
    ST_JTAG_RD = 2'd2,
    ST_JTAG_WR = 2'd3
  } ocimem_state_e;

  localparam int JDO_W         = 38;
  localparam int JDO_RD_REQ    = 35;
  localparam int JDO_CLR_ERR   = 34;
  localparam int JDO_ADDR_LSB  = 26;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/nios2_debug_ocimem_if.sv
// CPU-side Avalon debug-memory slave bundle.
//   address/chipselect/read/write/writedata/byteenable/debugaccess : master -> slave
//   readdata/waitrequest                                           : slave -> master
// waitrequest is combinational in the slave; readdata is valid whenever a
// read sees waitrequest low.
interface nios2_debug_ocimem_if #(
  parameter int ADDR_W = 8
);

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic              debugaccess;
  logic [31:0]       readdata;
  logic              waitrequest;

  modport master (
    output address, chipselect, read, write, writedata, byteenable, debugaccess,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, chipselect, read, write, writedata, byteenable, debugaccess,
    output readdata, waitrequest
  );

endinterface

// File: rtl/nios2_debug_ocimem_ram.sv
// Single-port debug RAM, 2^ADDR_W x 32 bit, byte-enabled write, one-cycle
// registered read (read-during-write returns the old word).
//   clk      : system clock
//   addr_i   : word address
//   we_i     : write enable
//   be_i     : byte lanes for the write
//   wdata_i  : write data
//   rdata_o  : registered read data (no reset; contents are not reset either)
module nios2_debug_ocimem_ram
  import nios2_debug_ocimem_pkg::*;
#(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  // Preloading is done by the memory build flow, which reads INIT_FILE off
  // this instance's parameters; the behavioural array starts unknown.
  localparam bit unused_init_file = (INIT_FILE != "");

  logic [31:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/nios2_debug_ocimem.sv
// Nios II debug on-chip memory controller. Arbitrates one debug RAM between
// JTAG requests (from the debug slave's system-clock stage) and the CPU's
// Avalon debug-memory slave port. JTAG always beats the CPU.
//   clk, reset_n               : system clock, async active-low reset
//   jdo                        : JTAG command word
//   take_action_ocimem_a       : address load (+ optional read request)
//   take_action_ocimem_b       : write request with data in jdo
//   take_no_action_ocimem_a    : streaming read at the current address
//   MonDReg                    : JTAG data register
//   monitor_ready              : last JTAG access done
//   monitor_error              : JTAG request dropped (overrun / collision)
//   avs                        : CPU Avalon slave bundle
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | RAM free; JTAG pending is launched first, else CPU read/write
// ST_CPU_RD  | RAM output holds CPU read data; completes the CPU read
// ST_JTAG_RD | RAM output holds JTAG read data; loads MonDReg, sets ready
// ST_JTAG_WR | MonDReg written to MonAReg on all lanes, sets ready
module nios2_debug_ocimem
  import nios2_debug_ocimem_pkg::*;
#(
  parameter int    ADDR_W    = 8,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  nios2_debug_ocimem_if.slave avs
);

  ocimem_state_e     state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q, mon_a_d;
  logic [31:0]       mon_d_q, mon_d_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              pend_q, pend_d;
  logic              pend_wr_q, pend_wr_d;
  logic [31:0]       readdata_q, readdata_d;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  logic              cpu_rd;
  logic              cpu_wr;
  logic              cpu_req;
  logic              jtag_done;
  logic              strobe_collision;
  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_wdata;
  logic              unused_jdo;

  assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_wdata  = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign cpu_rd  = avs.chipselect & avs.read;
  assign cpu_wr  = avs.chipselect & avs.write;
  assign cpu_req = avs.chipselect & (avs.read | avs.write);

  // More than one strobe in a cycle: ocimem_a has priority, the rest is lost.
  assign strobe_collision = (take_action_ocimem_a & (take_action_ocimem_b | take_no_action_ocimem_a))
                          | (take_action_ocimem_b & take_no_action_ocimem_a);

  // A CPU read always stalls in its IDLE cycle (RAM latency) and is released
  // in CPU_RD; anything else stalls while the RAM belongs to JTAG.
  assign avs.waitrequest = cpu_req &
                           ((state_q == ST_IDLE) ? (pend_q | avs.read)
                                                 : !((state_q == ST_CPU_RD) && avs.read));

  // The RAM output is handed straight to the CPU in the completing cycle;
  // the registered copy keeps readdata stable afterwards.
  assign avs.readdata = (state_q == ST_CPU_RD) ? ram_rdata : readdata_q;

  assign MonDReg       = mon_d_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;

  always_comb begin
    state_d    = state_q;
    ram_addr   = avs.address;
    ram_we     = 1'b0;
    ram_be     = avs.byteenable;
    ram_wdata  = avs.writedata;
    readdata_d = readdata_q;
    jtag_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          ram_addr = mon_a_q;
          state_d  = pend_wr_q ? ST_JTAG_WR : ST_JTAG_RD;
        end else if (cpu_rd) begin
          state_d = ST_CPU_RD;
        end else if (cpu_wr && avs.debugaccess) begin
          ram_we = 1'b1;
        end
      end
      ST_CPU_RD: begin
        readdata_d = ram_rdata;
        state_d    = ST_IDLE;
      end
      ST_JTAG_RD: begin
        ram_addr  = mon_a_q;
        jtag_done = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_JTAG_WR: begin
        ram_addr  = mon_a_q;
        ram_we    = 1'b1;
        ram_be    = 4'hF;
        ram_wdata = mon_d_q;
        jtag_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pending stays set through JTAG_RD/JTAG_WR, so "pend_q" covers both
  // waiting and in-service: any new queuing strobe then is dropped.
  always_comb begin
    mon_a_d   = mon_a_q;
    mon_d_d   = mon_d_q;
    ready_d   = ready_q;
    error_d   = error_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;

    if (jtag_done) begin
      ready_d = 1'b1;
      pend_d  = 1'b0;
      mon_a_d = mon_a_q + 1'b1;
      if (state_q == ST_JTAG_RD) mon_d_d = ram_rdata;
    end

    if (take_action_ocimem_a) begin
      if (jdo[JDO_CLR_ERR]) error_d = 1'b0;
      if (!jdo[JDO_RD_REQ]) begin
        mon_a_d = jdo_addr;
      end else if (pend_q) begin
        error_d = 1'b1;
      end else begin
        mon_a_d   = jdo_addr;
        pend_d    = 1'b1;
        pend_wr_d = 1'b0;
        ready_d   = 1'b0;
      end
    end else if (take_action_ocimem_b) begin
      if (pend_q) begin
        error_d = 1'b1;
      end else begin
        mon_d_d   = jdo_wdata;
        pend_d    = 1'b1;
        pend_wr_d = 1'b1;
        ready_d   = 1'b0;
      end
    end else if (take_no_action_ocimem_a) begin
      if (pend_q) begin
        error_d = 1'b1;
      end else begin
        pend_d    = 1'b1;
        pend_wr_d = 1'b0;
        ready_d   = 1'b0;
      end
    end

    if (strobe_collision) error_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mon_a_q    <= '0;
      mon_d_q    <= '0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_wr_q  <= 1'b0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      mon_a_q    <= mon_a_d;
      mon_d_q    <= mon_d_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      pend_q     <= pend_d;
      pend_wr_q  <= pend_wr_d;
      readdata_q <= readdata_d;
    end
  end

  nios2_debug_ocimem_ram #(
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .be_i    (ram_be),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

endmodule

// File: tb/tb_nios2_debug_ocimem.sv
// Directed bench for nios2_debug_ocimem. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_nios2_debug_ocimem;
  import nios2_debug_ocimem_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [37:0] jdo;
  logic        take_a, take_b, take_na;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;

  int checks = 0;
  int failures = 0;

  nios2_debug_ocimem_if #(.ADDR_W(8)) avs ();

  nios2_debug_ocimem #(.ADDR_W(8), .INIT_FILE("")) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_na),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avs                     (avs)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic strobe_a(input logic [7:0] addr, input logic rd, input logic clr);
    jdo = '0;
    jdo[35] = rd;
    jdo[34] = clr;
    jdo[33:26] = addr;
    take_a = 1'b1;
    cyc(1);
    take_a = 1'b0;
    jdo = '0;
  endtask

  task automatic strobe_b(input logic [31:0] data);
    jdo = '0;
    jdo[34:3] = data;
    take_b = 1'b1;
    cyc(1);
    take_b = 1'b0;
    jdo = '0;
  endtask

  task automatic strobe_na();
    take_na = 1'b1;
    cyc(1);
    take_na = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input logic dbg, input string tag);
    avs.chipselect = 1'b1;
    avs.write = 1'b1;
    avs.address = addr;
    avs.writedata = data;
    avs.byteenable = be;
    avs.debugaccess = dbg;
    @(negedge clk);
    chk({tag, "_wait"}, 32'(avs.waitrequest), 32'd0);
    cyc(1);
    avs.chipselect = 1'b0;
    avs.write = 1'b0;
    avs.debugaccess = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    avs.chipselect = 1'b1;
    avs.read = 1'b1;
    avs.address = addr;
    @(negedge clk);
    chk({tag, "_wait0"}, 32'(avs.waitrequest), 32'd1);
    cyc(1);
    @(negedge clk);
    chk({tag, "_wait1"}, 32'(avs.waitrequest), 32'd0);
    chk({tag, "_data"}, avs.readdata, exp);
    cyc(1);
    avs.chipselect = 1'b0;
    avs.read = 1'b0;
  endtask

  initial begin
    jdo = '0; take_a = 1'b0; take_b = 1'b0; take_na = 1'b0;
    avs.address = '0; avs.chipselect = 1'b0; avs.read = 1'b0; avs.write = 1'b0;
    avs.writedata = '0; avs.byteenable = '0; avs.debugaccess = 1'b0;

    // Reset values
    cyc(2);
    @(negedge clk);
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_ready", 32'(monitor_ready), 32'd0);
    chk("rst_error", 32'(monitor_error), 32'd0);
    chk("rst_readdata", avs.readdata, 32'h0);
    chk("rst_wait", 32'(avs.waitrequest), 32'd0);
    cyc(1);
    reset_n = 1'b1;
    cyc(1);

    // JTAG write 0xDEADBEEF to 0x10
    strobe_a(8'h10, 1'b0, 1'b0);
    strobe_b(32'hDEADBEEF);
    @(negedge clk);
    chk("jwr_mondreg", MonDReg, 32'hDEADBEEF);
    chk("jwr_busy_ready", 32'(monitor_ready), 32'd0);
    cyc(2);
    @(negedge clk);
    chk("jwr_ready", 32'(monitor_ready), 32'd1);
    chk("jwr_monareg", 32'(dut.mon_a_q), 32'h11);
    cyc(1);
    cpu_read(8'h10, 32'hDEADBEEF, "cpu_rd10");

    // Preload through the CPU port
    cpu_write(8'hFF, 32'hA5A50FF0, 4'hF, 1'b1, "pre_ff");
    cpu_write(8'h00, 32'h00001111, 4'hF, 1'b1, "pre_00");
    cpu_write(8'h20, 32'h20202020, 4'hF, 1'b1, "pre_20");
    cpu_write(8'h30, 32'h30303030, 4'hF, 1'b1, "pre_30");
    cpu_write(8'h50, 32'hAABBCCDD, 4'hF, 1'b1, "pre_50");

    // JTAG read at 0xFF, then streaming read wraps to 0x00
    strobe_a(8'hFF, 1'b1, 1'b0);
    @(negedge clk);
    chk("rdff_busy_ready", 32'(monitor_ready), 32'd0);
    cyc(2);
    @(negedge clk);
    chk("rdff_mondreg", MonDReg, 32'hA5A50FF0);
    chk("rdff_ready", 32'(monitor_ready), 32'd1);
    chk("rdff_monareg", 32'(dut.mon_a_q), 32'h00);
    cyc(1);
    strobe_na();
    @(negedge clk);
    chk("rd00_busy_ready", 32'(monitor_ready), 32'd0);
    cyc(2);
    @(negedge clk);
    chk("rd00_mondreg", MonDReg, 32'h00001111);
    chk("rd00_monareg", 32'(dut.mon_a_q), 32'h01);
    cyc(1);

    // CPU read meets a pending JTAG read in the same IDLE cycle
    strobe_a(8'h20, 1'b1, 1'b0);
    avs.chipselect = 1'b1; avs.read = 1'b1; avs.address = 8'h30;
    @(negedge clk);
    chk("col_wait_c0", 32'(avs.waitrequest), 32'd1);
    cyc(1);
    @(negedge clk);
    chk("col_wait_c1", 32'(avs.waitrequest), 32'd1);
    cyc(1);
    @(negedge clk);
    chk("col_wait_c2", 32'(avs.waitrequest), 32'd1);
    chk("col_jtag_data", MonDReg, 32'h20202020);
    chk("col_jtag_ready", 32'(monitor_ready), 32'd1);
    cyc(1);
    @(negedge clk);
    chk("col_wait_c3", 32'(avs.waitrequest), 32'd0);
    chk("col_cpu_data", avs.readdata, 32'h30303030);
    cyc(1);
    avs.chipselect = 1'b0; avs.read = 1'b0;

    // Overrun: write strobe one cycle after a read strobe is dropped
    strobe_a(8'h30, 1'b1, 1'b0);
    strobe_b(32'hCAFEF00D);
    @(negedge clk);
    chk("ovr_error", 32'(monitor_error), 32'd1);
    chk("ovr_mondreg_hold", MonDReg, 32'h20202020);
    cyc(1);
    @(negedge clk);
    chk("ovr_rd_data", MonDReg, 32'h30303030);
    chk("ovr_ready", 32'(monitor_ready), 32'd1);
    chk("ovr_monareg", 32'(dut.mon_a_q), 32'h31);
    cyc(1);
    strobe_a(8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk("clr_err", 32'(monitor_error), 32'd0);
    cyc(1);

    // Two strobes in one cycle: ocimem_a wins, error raised
    jdo = '0; jdo[35] = 1'b1; jdo[33:26] = 8'h10;
    take_a = 1'b1; take_b = 1'b1;
    cyc(1);
    take_a = 1'b0; take_b = 1'b0; jdo = '0;
    @(negedge clk);
    chk("dual_error", 32'(monitor_error), 32'd1);
    cyc(2);
    @(negedge clk);
    chk("dual_a_wins", MonDReg, 32'hDEADBEEF);
    cyc(1);
    strobe_a(8'h00, 1'b0, 1'b1);
    @(negedge clk);
    chk("dual_clr_err", 32'(monitor_error), 32'd0);
    cyc(1);

    // Byte-enabled CPU write, then a write without debugaccess
    cpu_write(8'h50, 32'h12345678, 4'b0011, 1'b1, "be_lo");
    cpu_write(8'h50, 32'h99999999, 4'hF, 1'b0, "nodbg");
    cpu_read(8'h50, 32'hAABB5678, "be_rd");

    // Reset asserted while the FSM is in JTAG_RD
    strobe_a(8'h10, 1'b1, 1'b0);
    cyc(1);
    chk("mid_state_pre", 32'(dut.state_q), 32'(ST_JTAG_RD));
    reset_n = 1'b0;
    #1;
    chk("mid_mondreg", MonDReg, 32'h0);
    chk("mid_ready", 32'(monitor_ready), 32'd0);
    chk("mid_error", 32'(monitor_error), 32'd0);
    chk("mid_readdata", avs.readdata, 32'h0);
    chk("mid_state", 32'(dut.state_q), 32'(ST_IDLE));
    cyc(1);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(monitor_ready), 32'd0);
      cyc(1);
    end
    chk("post_rst_mondreg", MonDReg, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
